divider_check_mul: RTL
======================

# divider_check_mul

Sequential shift-add multiply-accumulate that rebuilds a dividend from the divider's results: `dividend = quo * divisor + rem`. It sits beside the repeated-subtraction divider and uses the same operand widths. Its roles are round-trip checking of divider results in the bench, and regeneration of dividends in datapaths that store quotient and remainder. One operation is in flight at a time, under a start/busy/done handshake.

## Interface
- `WIDTH`, default 4: divisor width. Quotient and remainder are 2*WIDTH bits wide; the result is 3*WIDTH bits wide.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only while idle.
- `quo` input 2*WIDTH: multiplicand.
- `divisor` input WIDTH: multiplier.
- `rem` input 2*WIDTH: accumulator seed.
- `busy` output 1: operation in progress, from the capture edge until the end of the done cycle.
- `done` output 1: one-cycle pulse. The result outputs are valid and stable from this cycle on.
- `dividend` output 3*WIDTH: result. Held until the next capture.
- `ovf` output 1: set when `dividend[3*WIDTH-1:2*WIDTH]` is nonzero, meaning the result does not fit the 2*WIDTH divider input.
- `rem_err` output 1: set when `rem >= divisor` at capture, meaning the quotient/remainder pair is inconsistent. This includes `divisor == 0`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - If `start` is 1, the block captures the following:
    - multiplicand register `mc <= {WIDTH'b0, quo}` (3*WIDTH bits)
    - multiplier register `mp <= divisor`
    - accumulator `acc <= {WIDTH'b0, rem}`
    - `rem_err_q <= (rem >= divisor)`
    - iteration count `cnt <= 0`
  - It then moves to RUN.
- **RUN, one iteration per clock:**
  - if `mp[0]`, then `acc <= acc + mc`
  - `mc <= mc << 1`
  - `mp <= mp >> 1`
  - `cnt <= cnt + 1`
- **RUN exit:** when the iteration with `cnt == WIDTH-1` completes, the FSM moves to DONE. On that same edge it loads `dividend <= final acc`, `ovf` and `rem_err`.
- **DONE:** `done = 1` for exactly one cycle, then the FSM returns to IDLE.
- **Arithmetic:** all sums are 3*WIDTH bits and unsigned. They cannot overflow, because the maximum is (2^(2W)-1)*2^W < 2^(3W). No truncation anywhere.
- **start while busy:** ignored, with no queuing. `start` held high through DONE is not accepted in the DONE cycle; it is accepted on the first IDLE edge after.
- **Input changes after capture:** `quo`, `divisor` and `rem` may change freely after the capture edge without affecting the result.
- **Reset (any state, including mid-RUN):**
  - FSM goes to IDLE.
  - `busy`, `done`, `ovf` and `rem_err` go to 0; `dividend` goes to 0.
  - Internal registers are cleared, and the operation in flight is discarded.

## Timing
- Capture edge E0. RUN iterations on edges E1..EW; the result is registered on EW.
- `done` is high in the cycle after EW, for one cycle. The FSM returns to IDLE on E(W+1).
- `busy` is high from after E0 through the DONE cycle. The earliest next capture is E(W+2), giving a throughput of one op per W+2 cycles.
- `dividend`, `ovf` and `rem_err` are registered outputs with no combinational path from inputs.

## Configuration
- Macro: `DIVIDER_CHECK_MUL_EARLY_EXIT_EN`.
- **Defined:**
  - RUN also exits when the next-state `mp` is zero, i.e. no set multiplier bits remain.
  - At least one iteration always runs.
  - Latency becomes (index of the divisor's highest set bit + 1) iterations. `divisor == 0` takes 1 iteration.
  - Results are identical to the fixed-latency build.
- **Undefined:** always exactly WIDTH iterations, with fixed latency.

## Structure
- Shared package `divider_pkg` holds:
  - the FSM state localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - width helper constants: QW=2*WIDTH, PW=3*WIDTH
- One combinational sub-module, `mul_step`, performs one iteration:
  - inputs: `acc`, `mc`, `mp`
  - outputs: next `acc`, next `mc`, next `mp`, and `mp_zero`
- The top level holds the FSM, the counter, capture and the output registers.

## Test plan (WIDTH=4)
- quo=13, divisor=5, rem=3, start pulse:
  - dividend=68, ovf=0, rem_err=0
  - done exactly 4 edges after capture (fixed build)
- quo=255, divisor=15, rem=14:
  - dividend=3839, ovf=1, rem_err=0
- quo=200, divisor=0, rem=7:
  - dividend=7, rem_err=1, ovf=0
  - with the macro defined, done after 1 iteration
- start re-asserted with new operands while busy:
  - ignored; first result unchanged
  - the next start is accepted only after done has dropped
- rst_n low during iteration 2, then a new op quo=3, divisor=3, rem=2:
  - during reset: all outputs 0
  - new op gives dividend=11 with normal latency
- Round trip: for random dividend/divisor pairs (divisor != 0), feed the divider outputs into this block:
  - dividend matches the original
  - rem_err=0, ovf=0

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and width helpers for the divider family.
// No logic; latency and backpressure are defined by the modules that import this package.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient/remainder width and product width for a given divisor width.
  function automatic int qw(input int width);
    return 2 * width;
  endfunction

  function automatic int pw(input int width);
    return 3 * width;
  endfunction

endpackage

// File: rtl/divider_check_mul_mul_step.sv
// One shift-add multiply iteration: conditional accumulate, shift multiplicand left, multiplier right.
// Purely combinational, zero latency; no handshake.
module mul_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [pw(WIDTH)-1:0] acc,
  input  logic [pw(WIDTH)-1:0] mc,
  input  logic [WIDTH-1:0]     mp,
  output logic [pw(WIDTH)-1:0] acc_nxt,
  output logic [pw(WIDTH)-1:0] mc_nxt,
  output logic [WIDTH-1:0]     mp_nxt,
  output logic                 mp_zero
);

  assign acc_nxt = mp[0] ? acc + mc : acc;
  assign mc_nxt  = mc << 1;
  assign mp_nxt  = mp >> 1;
  assign mp_zero = (mp_nxt == '0);

endmodule

// File: rtl/divider_check_mul.sv
// Rebuilds dividend = quo*divisor + rem by shift-add; optional DIVIDER_CHECK_MUL_EARLY_EXIT_EN.
// Latency WIDTH iterations (fewer with early exit) plus a done cycle; start ignored while busy.
module divider_check_mul
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [2*WIDTH-1:0]   rem,
  output logic                 busy,
  output logic                 done,
  output logic [3*WIDTH-1:0]   dividend,
  output logic                 ovf,
  output logic                 rem_err
);

  localparam int QW = qw(WIDTH);
  localparam int PW = pw(WIDTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   acc, mc, acc_nxt, mc_nxt;
  logic [WIDTH-1:0] mp, mp_nxt;
  logic            mp_zero;
  logic [CW-1:0]   cnt;
  logic            rem_err_q;
  logic            last_iter;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .mc      (mc),
    .mp      (mp),
    .acc_nxt (acc_nxt),
    .mc_nxt  (mc_nxt),
    .mp_nxt  (mp_nxt),
    .mp_zero (mp_zero)
  );

`ifdef DIVIDER_CHECK_MUL_EARLY_EXIT_EN
  // Once no multiplier bits remain, further iterations cannot change acc.
  assign last_iter = (cnt == CW'(WIDTH-1)) || mp_zero;
`else
  assign last_iter = (cnt == CW'(WIDTH-1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      cnt       <= '0;
      rem_err_q <= 1'b0;
      dividend  <= '0;
      ovf       <= 1'b0;
      rem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mc        <= {{WIDTH{1'b0}}, quo};
          mp        <= divisor;
          acc       <= {{WIDTH{1'b0}}, rem};
          rem_err_q <= ({{WIDTH{1'b0}}, rem} >= {{QW-WIDTH{1'b0}}, divisor});
          cnt       <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          mc  <= mc_nxt;
          mp  <= mp_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            dividend <= acc_nxt;
            ovf      <= |acc_nxt[PW-1:QW];
            rem_err  <= rem_err_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
